xbar_switch_rr: RTL and testbench

- NP-port single-clock packet crossbar: generalised successor of the fixed 4-port switch.
- Each input port has a 2**DEPTH-word FIFO. Each FIFO head carries a destination address and is routed to one of NP output registers.
- Each output has a round-robin arbiter that grants among the input FIFO heads addressed to it.
- Sits between NP producer (Y side, validtx/acktx) and NP consumer (X side, validrx/ackrx) endpoints; exports per-input occupancy for status/LED logic.

---
 rtl/xbar_switch_rr.sv | 175 +++++++++++++++++
 tb/tb_xbar_switch_rr.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/xbar_switch_rr.sv
// NP-port packet crossbar: per-input FIFO, per-output round-robin arbiter and
// holding register. Input heads carry a destination; outputs drain via ackrx.
module xbar_switch_rr #(
    parameter  int NP    = 4,
    parameter  int DW    = 4,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(NP)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NP-1:0]           Y_validtx,
    input  logic [NP*AW-1:0]        Y_adr_i,
    input  logic [NP*DW-1:0]        Y_dat_i,
    output logic [NP-1:0]           Y_acktx,
    output logic [NP-1:0]           X_validrx,
    output logic [NP*DW-1:0]        X_dat_o,
    output logic [NP*AW-1:0]        X_src_o,
    input  logic [NP-1:0]           X_ackrx,
    output logic [NP*(DEPTH+1)-1:0] occ_o
);

    localparam int FD = 1 << DEPTH;
    localparam int CW = DEPTH + 1;
    localparam int EW = AW + DW;

    logic [EW-1:0]    mem_q    [NP][FD];
    logic [DEPTH-1:0] wr_ptr_q [NP];
    logic [DEPTH-1:0] wr_ptr_d [NP];
    logic [DEPTH-1:0] rd_ptr_q [NP];
    logic [DEPTH-1:0] rd_ptr_d [NP];
    logic [CW-1:0]    cnt_q    [NP];
    logic [CW-1:0]    cnt_d    [NP];
    logic [AW-1:0]    ptr_q    [NP];
    logic [AW-1:0]    ptr_d    [NP];
    logic [NP-1:0]    xv_q;
    logic [NP-1:0]    xv_d;
    logic [DW-1:0]    xdat_q   [NP];
    logic [DW-1:0]    xdat_d   [NP];
    logic [AW-1:0]    xsrc_q   [NP];
    logic [AW-1:0]    xsrc_d   [NP];

    logic [NP-1:0]    full_s;
    logic [NP-1:0]    empty_s;
    logic [NP-1:0]    push_s;
    logic [NP-1:0]    pop_s;
    logic [NP-1:0]    gnt_s;
    logic [AW-1:0]    head_adr_s [NP];
    logic [DW-1:0]    head_dat_s [NP];
    logic [AW-1:0]    gidx_s     [NP];

    // FIFO status, head decode and push qualification (no accepts while in reset)
    always_comb begin
        logic [EW-1:0] ent;
        ent    = {EW{1'b0}};
        full_s = {NP{1'b0}};
        empty_s = {NP{1'b0}};
        push_s = {NP{1'b0}};
        for (int k = 0; k < NP; k++) begin
            ent           = mem_q[k][rd_ptr_q[k]];
            full_s[k]     = (cnt_q[k] == CW'(FD));
            empty_s[k]    = (cnt_q[k] == {CW{1'b0}});
            head_adr_s[k] = ent[EW-1:DW];
            head_dat_s[k] = ent[DW-1:0];
            push_s[k]     = Y_validtx[k] & ~full_s[k] & rst_ni;
        end
    end

    // Per-output round-robin scan starting just after the last granted input
    always_comb begin
        logic          found;
        logic [AW-1:0] idx;
        found = 1'b0;
        idx   = {AW{1'b0}};
        gnt_s = {NP{1'b0}};
        pop_s = {NP{1'b0}};
        for (int j = 0; j < NP; j++) begin
            found     = 1'b0;
            gidx_s[j] = {AW{1'b0}};
            for (int o = 1; o <= NP; o++) begin
                idx = ptr_q[j] + AW'(o);
                if (!found && !empty_s[idx] && (head_adr_s[idx] == AW'(j))) begin
                    found     = 1'b1;
                    gidx_s[j] = idx;
                end else begin
                    found = found;
                end
            end
            gnt_s[j] = found & (~xv_q[j] | X_ackrx[j]);
        end
        for (int k = 0; k < NP; k++) begin
            for (int j = 0; j < NP; j++) begin
                if (gnt_s[j] && (gidx_s[j] == AW'(k))) begin
                    pop_s[k] = 1'b1;
                end else begin
                    pop_s[k] = pop_s[k];
                end
            end
        end
    end

    // Next-state for FIFO pointers/counts and output holding registers
    always_comb begin
        xv_d = xv_q;
        for (int k = 0; k < NP; k++) begin
            wr_ptr_d[k] = push_s[k] ? wr_ptr_q[k] + {{(DEPTH-1){1'b0}}, 1'b1} : wr_ptr_q[k];
            rd_ptr_d[k] = pop_s[k]  ? rd_ptr_q[k] + {{(DEPTH-1){1'b0}}, 1'b1} : rd_ptr_q[k];
            cnt_d[k]    = cnt_q[k] + CW'(push_s[k]) - CW'(pop_s[k]);
        end
        for (int j = 0; j < NP; j++) begin
            ptr_d[j]  = ptr_q[j];
            xdat_d[j] = xdat_q[j];
            xsrc_d[j] = xsrc_q[j];
            if (gnt_s[j]) begin
                xv_d[j]   = 1'b1;
                xdat_d[j] = head_dat_s[gidx_s[j]];
                xsrc_d[j] = gidx_s[j];
                ptr_d[j]  = gidx_s[j];
            end else if (X_ackrx[j]) begin
                xv_d[j] = 1'b0;
            end else begin
                xv_d[j] = xv_q[j];
            end
        end
    end

    // State registers; pointers reset to NP-1 so input 0 wins first
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            xv_q <= {NP{1'b0}};
            for (int k = 0; k < NP; k++) begin
                wr_ptr_q[k] <= {DEPTH{1'b0}};
                rd_ptr_q[k] <= {DEPTH{1'b0}};
                cnt_q[k]    <= {CW{1'b0}};
                ptr_q[k]    <= AW'(NP - 1);
                xdat_q[k]   <= {DW{1'b0}};
                xsrc_q[k]   <= {AW{1'b0}};
            end
        end else begin
            xv_q <= xv_d;
            for (int k = 0; k < NP; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                cnt_q[k]    <= cnt_d[k];
                ptr_q[k]    <= ptr_d[k];
                xdat_q[k]   <= xdat_d[k];
                xsrc_q[k]   <= xsrc_d[k];
            end
        end
    end

    // FIFO storage; contents are don't-care until the count covers them
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NP; k++) begin
            if (push_s[k]) begin
                mem_q[k][wr_ptr_q[k]] <= {Y_adr_i[k*AW +: AW], Y_dat_i[k*DW +: DW]};
            end
        end
    end

    // Flatten per-port state onto the packed output buses
    always_comb begin
        X_dat_o = {(NP*DW){1'b0}};
        X_src_o = {(NP*AW){1'b0}};
        occ_o   = {(NP*CW){1'b0}};
        for (int k = 0; k < NP; k++) begin
            X_dat_o[k*DW +: DW] = xdat_q[k];
            X_src_o[k*AW +: AW] = xsrc_q[k];
            occ_o[k*CW +: CW]   = cnt_q[k];
        end
    end

    assign Y_acktx   = push_s;
    assign X_validrx = xv_q;

endmodule

// File: tb/tb_xbar_switch_rr.sv
// Directed bench for xbar_switch_rr with NP=4, DW=4, DEPTH=2.
module tb_xbar_switch_rr;

    localparam int NP = 4;
    localparam int DW = 4;
    localparam int AW = 2;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b1;
    logic [NP-1:0]     Y_validtx = '0;
    logic [NP*AW-1:0]  Y_adr_i = '0;
    logic [NP*DW-1:0]  Y_dat_i = '0;
    logic [NP-1:0]     Y_acktx;
    logic [NP-1:0]     X_validrx;
    logic [NP*DW-1:0]  X_dat_o;
    logic [NP*AW-1:0]  X_src_o;
    logic [NP-1:0]     X_ackrx = '0;
    logic [NP*CW-1:0]  occ_o;

    int total = 0;
    int passed = 0;

    xbar_switch_rr #(.NP(NP), .DW(DW), .DEPTH(2)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .Y_validtx(Y_validtx), .Y_adr_i(Y_adr_i), .Y_dat_i(Y_dat_i), .Y_acktx(Y_acktx),
        .X_validrx(X_validrx), .X_dat_o(X_dat_o), .X_src_o(X_src_o), .X_ackrx(X_ackrx),
        .occ_o(occ_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int k, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        Y_validtx[k]        = v;
        Y_adr_i[k*AW +: AW] = a;
        Y_dat_i[k*DW +: DW] = d;
    endtask

    task automatic do_reset();
        Y_validtx = '0;
        X_ackrx   = '0;
        rst_ni    = 1'b0;
        tick();
        @(negedge clk);
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        Y_validtx = 4'hF;
        #1 rst_ni = 1'b0;
        #2;
        total++; if (Y_acktx !== 4'h0) $display("FAIL rst_ack got %h exp 0", Y_acktx); else passed++;
        total++; if (X_validrx !== 4'h0) $display("FAIL rst_valid got %h exp 0", X_validrx); else passed++;
        total++; if (occ_o !== 12'h000) $display("FAIL rst_occ got %h exp 0", occ_o); else passed++;
        total++; if (X_dat_o !== 16'h0000) $display("FAIL rst_dat got %h exp 0", X_dat_o); else passed++;
        total++; if (X_src_o !== 8'h00) $display("FAIL rst_src got %h exp 0", X_src_o); else passed++;
        tick();
        total++; if (occ_o !== 12'h000) $display("FAIL rst_occ_hold got %h exp 0", occ_o); else passed++;
        Y_validtx = '0;
        @(negedge clk);
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        X_ackrx = 4'b0100;
        set_in(0, 1'b1, 2'd2, 4'hA);
        #1;
        total++; if (Y_acktx !== 4'b0001) $display("FAIL single_ack got %b exp 0001", Y_acktx); else passed++;
        tick();
        set_in(0, 1'b0, 2'd2, 4'hA);
        #1;
        total++; if (Y_acktx !== 4'b0000) $display("FAIL single_ack_drop got %b exp 0000", Y_acktx); else passed++;
        total++; if (X_validrx !== 4'b0000) $display("FAIL single_early got %b exp 0000", X_validrx); else passed++;
        total++; if (occ_o[0 +: CW] !== 3'd1) $display("FAIL single_occ got %0d exp 1", occ_o[0 +: CW]); else passed++;
        tick();
        total++; if (X_validrx !== 4'b0100) $display("FAIL single_valid got %b exp 0100", X_validrx); else passed++;
        total++; if (X_dat_o[2*DW +: DW] !== 4'hA) $display("FAIL single_dat got %h exp a", X_dat_o[2*DW +: DW]); else passed++;
        total++; if (X_src_o[2*AW +: AW] !== 2'd0) $display("FAIL single_src got %0d exp 0", X_src_o[2*AW +: AW]); else passed++;
        total++; if (occ_o[0 +: CW] !== 3'd0) $display("FAIL single_occ2 got %0d exp 0", occ_o[0 +: CW]); else passed++;
        tick();
        total++; if (X_validrx !== 4'b0000) $display("FAIL single_pulse got %b exp 0000", X_validrx); else passed++;
    endtask

    task automatic test_fill_and_full_pop();
        logic [DW-1:0] exp_dat [3];
        exp_dat[0] = 4'd4; exp_dat[1] = 4'd5; exp_dat[2] = 4'd6;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            set_in(3, 1'b1, 2'd1, DW'(i));
            #1;
            total++; if (Y_acktx[3] !== 1'b1) $display("FAIL fill_ack%0d got %b exp 1", i, Y_acktx[3]); else passed++;
            tick();
        end
        total++; if (occ_o[3*CW +: CW] !== 3'd4) $display("FAIL fill_occ got %0d exp 4", occ_o[3*CW +: CW]); else passed++;
        total++; if (X_validrx !== 4'b0010) $display("FAIL fill_valid got %b exp 0010", X_validrx); else passed++;
        total++; if (X_dat_o[1*DW +: DW] !== 4'd1) $display("FAIL fill_dat got %h exp 1", X_dat_o[1*DW +: DW]); else passed++;
        total++; if (X_src_o[1*AW +: AW] !== 2'd3) $display("FAIL fill_src got %0d exp 3", X_src_o[1*AW +: AW]); else passed++;
        set_in(3, 1'b1, 2'd1, 4'd6);
        #1;
        total++; if (Y_acktx[3] !== 1'b0) $display("FAIL full_ack got %b exp 0", Y_acktx[3]); else passed++;
        tick();
        total++; if (occ_o[3*CW +: CW] !== 3'd4) $display("FAIL full_occ got %0d exp 4", occ_o[3*CW +: CW]); else passed++;
        X_ackrx = 4'b0010;
        #1;
        total++; if (Y_acktx[3] !== 1'b0) $display("FAIL fullpop_ack got %b exp 0", Y_acktx[3]); else passed++;
        tick();
        total++; if (occ_o[3*CW +: CW] !== 3'd3) $display("FAIL fullpop_occ got %0d exp 3", occ_o[3*CW +: CW]); else passed++;
        total++; if (X_dat_o[1*DW +: DW] !== 4'd2) $display("FAIL fullpop_dat got %h exp 2", X_dat_o[1*DW +: DW]); else passed++;
        #1;
        total++; if (Y_acktx[3] !== 1'b1) $display("FAIL nextpush_ack got %b exp 1", Y_acktx[3]); else passed++;
        tick();
        set_in(3, 1'b0, 2'd1, 4'd0);
        total++; if (occ_o[3*CW +: CW] !== 3'd3) $display("FAIL pushpop_occ got %0d exp 3", occ_o[3*CW +: CW]); else passed++;
        total++; if (X_dat_o[1*DW +: DW] !== 4'd3) $display("FAIL pushpop_dat got %h exp 3", X_dat_o[1*DW +: DW]); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (X_dat_o[1*DW +: DW] !== exp_dat[i]) $display("FAIL drain_dat%0d got %h exp %h", i, X_dat_o[1*DW +: DW], exp_dat[i]); else passed++;
        end
        tick();
        total++; if (X_validrx !== 4'b0000) $display("FAIL drain_end got %b exp 0000", X_validrx); else passed++;
    endtask

    task automatic test_round_robin();
        do_reset();
        X_ackrx = 4'b0001;
        for (int k = 0; k < NP; k++) set_in(k, 1'b1, 2'd0, DW'(k));
        tick();
        total++; if (X_validrx[0] !== 1'b0) $display("FAIL rr_early got %b exp 0", X_validrx[0]); else passed++;
        tick();
        for (int n = 0; n < 12; n++) begin
            total++; if (X_validrx[0] !== 1'b1) $display("FAIL rr_gap%0d got %b exp 1", n, X_validrx[0]); else passed++;
            total++; if (X_src_o[0 +: AW] !== AW'(n % 4)) $display("FAIL rr_src%0d got %0d exp %0d", n, X_src_o[0 +: AW], n % 4); else passed++;
            total++; if (X_dat_o[0 +: DW] !== DW'(n % 4)) $display("FAIL rr_dat%0d got %h exp %0d", n, X_dat_o[0 +: DW], n % 4); else passed++;
            tick();
        end
        Y_validtx = '0;
    endtask

    task automatic test_parallel();
        do_reset();
        X_ackrx = 4'b0110;
        set_in(0, 1'b1, 2'd1, 4'h5);
        set_in(1, 1'b1, 2'd2, 4'h9);
        tick();
        Y_validtx = '0;
        tick();
        total++; if (X_validrx !== 4'b0110) $display("FAIL par_valid got %b exp 0110", X_validrx); else passed++;
        total++; if (X_dat_o[1*DW +: DW] !== 4'h5) $display("FAIL par_dat1 got %h exp 5", X_dat_o[1*DW +: DW]); else passed++;
        total++; if (X_dat_o[2*DW +: DW] !== 4'h9) $display("FAIL par_dat2 got %h exp 9", X_dat_o[2*DW +: DW]); else passed++;
        total++; if (X_src_o !== 8'b00_01_00_00) $display("FAIL par_src got %b exp 00010000", X_src_o); else passed++;
        tick();
        total++; if (X_validrx !== 4'b0000) $display("FAIL par_drop got %b exp 0000", X_validrx); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < NP; k++) set_in(k, 1'b1, AW'(k), DW'(k));
            tick();
        end
        Y_validtx = '0;
        total++; if (occ_o !== 12'b011_011_011_011) $display("FAIL mid_occ got %b exp 011011011011", occ_o); else passed++;
        total++; if (X_validrx !== 4'hF) $display("FAIL mid_valid got %b exp 1111", X_validrx); else passed++;
        rst_ni = 1'b0;
        #1;
        total++; if (occ_o !== 12'h000) $display("FAIL async_occ got %h exp 0", occ_o); else passed++;
        total++; if (X_validrx !== 4'h0) $display("FAIL async_valid got %b exp 0000", X_validrx); else passed++;
        @(negedge clk);
        rst_ni = 1'b1;
        tick();
        X_ackrx = 4'b0001;
        set_in(3, 1'b1, 2'd0, 4'hB);
        set_in(1, 1'b1, 2'd0, 4'h9);
        set_in(0, 1'b1, 2'd0, 4'h8);
        tick();
        Y_validtx = '0;
        tick();
        total++; if (X_src_o[0 +: AW] !== 2'd0) $display("FAIL post_src0 got %0d exp 0", X_src_o[0 +: AW]); else passed++;
        total++; if (X_dat_o[0 +: DW] !== 4'h8) $display("FAIL post_dat0 got %h exp 8", X_dat_o[0 +: DW]); else passed++;
        tick();
        total++; if (X_src_o[0 +: AW] !== 2'd1) $display("FAIL post_src1 got %0d exp 1", X_src_o[0 +: AW]); else passed++;
        tick();
        total++; if (X_src_o[0 +: AW] !== 2'd3) $display("FAIL post_src2 got %0d exp 3", X_src_o[0 +: AW]); else passed++;
        total++; if (X_dat_o[0 +: DW] !== 4'hB) $display("FAIL post_dat2 got %h exp b", X_dat_o[0 +: DW]); else passed++;
        tick();
        total++; if (X_validrx[0] !== 1'b0) $display("FAIL post_end got %b exp 0", X_validrx[0]); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_and_full_pop();
        test_round_robin();
        test_parallel();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
